// File: rtl/uart_cmd_decoder.sv
// Decodes 4-byte SYNC/ADDR/DATA/CSUM command frames from a UART byte stream
// into single register writes over a valid/ready port, with timeout and error counting.
module uart_cmd_decoder #(
  parameter logic [7:0] SYNC_BYTE    = 8'hA5,
  parameter int         TIMEOUT_CLKS = 2560,
  parameter int         TO_WIDTH     = 16
) (
  input  logic       i_Clock,
  input  logic       i_Rst_n,
  input  logic       i_Rx_DV,
  input  logic [7:0] i_Rx_Byte,
  output logic       o_Wr_Valid,
  input  logic       i_Wr_Ready,
  output logic [7:0] o_Wr_Addr,
  output logic [7:0] o_Wr_Data,
  output logic [7:0] o_Err_Count,
  output logic       o_Busy
);

  localparam logic [TO_WIDTH-1:0] TO_LAST = TO_WIDTH'(TIMEOUT_CLKS - 1);

  typedef enum logic [2:0] {
    S_HUNT  = 3'd0,
    S_ADDR  = 3'd1,
    S_DATA  = 3'd2,
    S_CSUM  = 3'd3,
    S_ISSUE = 3'd4
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic [TO_WIDTH-1:0] to_cnt;
  logic [TO_WIDTH-1:0] to_cnt_nxt;
  logic [7:0]          addr_hold;
  logic [7:0]          data_hold;
  logic                wr_valid_nxt;
  logic [7:0]          wr_addr_nxt;
  logic [7:0]          wr_data_nxt;
  logic [7:0]          err_nxt;
  logic                err_event;
  logic                in_frame;
  logic                timeout;
  logic                csum_ok;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? 8'hFF : v + 8'd1;
  endfunction

  assign in_frame = (state == S_ADDR) || (state == S_DATA) || (state == S_CSUM);
  assign timeout  = in_frame && !i_Rx_DV && (to_cnt == TO_LAST);
  assign csum_ok  = (i_Rx_Byte == (addr_hold ^ data_hold));

  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state       <= S_HUNT;
      o_Busy      <= 1'b0;
      to_cnt      <= '0;
      o_Wr_Valid  <= 1'b0;
      o_Wr_Addr   <= 8'h00;
      o_Wr_Data   <= 8'h00;
      o_Err_Count <= 8'h00;
    end else begin
      state       <= state_nxt;
      o_Busy      <= (state_nxt != S_HUNT);
      to_cnt      <= to_cnt_nxt;
      o_Wr_Valid  <= wr_valid_nxt;
      o_Wr_Addr   <= wr_addr_nxt;
      o_Wr_Data   <= wr_data_nxt;
      o_Err_Count <= err_nxt;
    end
  end

  // Holding registers only carry frame payload; they need no reset.
  always_ff @(posedge i_Clock) begin
    if (state == S_ADDR && i_Rx_DV) addr_hold <= i_Rx_Byte;
    if (state == S_DATA && i_Rx_DV) data_hold <= i_Rx_Byte;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_HUNT:  if (i_Rx_DV && i_Rx_Byte == SYNC_BYTE) state_nxt = S_ADDR;
      S_ADDR:  if (i_Rx_DV) state_nxt = S_DATA;
               else if (timeout) state_nxt = S_HUNT;
      S_DATA:  if (i_Rx_DV) state_nxt = S_CSUM;
               else if (timeout) state_nxt = S_HUNT;
      S_CSUM:  if (i_Rx_DV) state_nxt = csum_ok ? S_ISSUE : S_HUNT;
               else if (timeout) state_nxt = S_HUNT;
      S_ISSUE: if (i_Wr_Ready) state_nxt = S_HUNT;
      default: state_nxt = S_HUNT;
    endcase
  end

  always_comb begin
    wr_valid_nxt = o_Wr_Valid;
    wr_addr_nxt  = o_Wr_Addr;
    wr_data_nxt  = o_Wr_Data;
    err_event    = 1'b0;
    to_cnt_nxt   = '0;
    if (in_frame && !i_Rx_DV && !timeout) to_cnt_nxt = to_cnt + TO_WIDTH'(1);
    case (state)
      S_ADDR, S_DATA: if (timeout) err_event = 1'b1;
      S_CSUM: begin
        if (i_Rx_DV) begin
          if (csum_ok) begin
            wr_valid_nxt = 1'b1;
            wr_addr_nxt  = addr_hold;
            wr_data_nxt  = data_hold;
          end else begin
            err_event = 1'b1;
          end
        end else if (timeout) begin
          err_event = 1'b1;
        end
      end
      S_ISSUE: begin
        // A byte arriving while a write is pending is an overrun; the write itself is untouched.
        if (i_Rx_DV) err_event = 1'b1;
        if (i_Wr_Ready) wr_valid_nxt = 1'b0;
      end
      default: ;
    endcase
    err_nxt = err_event ? sat_inc(o_Err_Count) : o_Err_Count;
  end

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Self-checking bench for uart_cmd_decoder: directed frames plus randomized traffic,
// compared every cycle against a queue-based frame model.
module tb_uart_cmd_decoder;

  localparam logic [7:0] SYNC = 8'hA5;
  localparam int         TOC  = 2560;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       dv = 1'b0;
  logic [7:0] rxb = 8'h00;
  logic       ready = 1'b1;
  logic       wr_valid;
  logic [7:0] wr_addr;
  logic [7:0] wr_data;
  logic [7:0] err_count;
  logic       busy;

  int n_cmp = 0;
  int n_bad = 0;
  bit rnd_ready = 1'b0;

  uart_cmd_decoder #(.SYNC_BYTE(SYNC), .TIMEOUT_CLKS(TOC), .TO_WIDTH(16)) dut (
    .i_Clock(clk), .i_Rst_n(rst_n), .i_Rx_DV(dv), .i_Rx_Byte(rxb),
    .o_Wr_Valid(wr_valid), .i_Wr_Ready(ready), .o_Wr_Addr(wr_addr),
    .o_Wr_Data(wr_data), .o_Err_Count(err_count), .o_Busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: collects payload bytes of the current frame in a queue.
  logic [7:0] fq[$];
  bit         m_in_frame;
  int         m_idle;
  bit         m_valid;
  logic [7:0] m_addr, m_data;
  int         m_err;
  bit         m_busy;

  function automatic void bump();
    if (m_err < 255) m_err++;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fq.delete();
      m_in_frame = 0; m_idle = 0; m_valid = 0;
      m_addr = 8'h00; m_data = 8'h00; m_err = 0; m_busy = 0;
    end else begin
      if (m_valid) begin
        if (dv) bump();
        if (ready) m_valid = 0;
      end else if (m_in_frame) begin
        if (dv) begin
          m_idle = 0;
          if (fq.size() < 2) fq.push_back(rxb);
          else begin
            if (rxb == (fq[0] ^ fq[1])) begin
              m_addr = fq[0]; m_data = fq[1]; m_valid = 1;
            end else bump();
            fq.delete();
            m_in_frame = 0;
          end
        end else begin
          m_idle++;
          if (m_idle == TOC) begin
            bump();
            fq.delete();
            m_in_frame = 0;
          end
        end
      end else if (dv && rxb == SYNC) begin
        m_in_frame = 1;
        m_idle = 0;
      end
      m_busy = m_in_frame || m_valid;
    end
  end

  always @(negedge clk) begin
    check("cyc_valid", {31'd0, wr_valid}, {31'd0, m_valid});
    check("cyc_addr", {24'd0, wr_addr}, {24'd0, m_addr});
    check("cyc_data", {24'd0, wr_data}, {24'd0, m_data});
    check("cyc_err", {24'd0, err_count}, m_err);
    check("cyc_busy", {31'd0, busy}, {31'd0, m_busy});
  end

  task automatic tick();
    @(posedge clk);
    #2;
    if (rnd_ready) ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic send(input logic [7:0] b);
    dv = 1'b1; rxb = b;
    tick();
    dv = 1'b0; rxb = $urandom_range(0, 255);
  endtask

  task automatic frame(input logic [7:0] a, input logic [7:0] d, input logic [7:0] c);
    send(SYNC); send(a); send(d); send(c);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int vcount;
    repeat (3) tick();
    check("rst_valid", {31'd0, wr_valid}, 0);
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_err", {24'd0, err_count}, 0);
    check("rst_addr", {24'd0, wr_addr}, 0);
    rst_n = 1'b1;
    tick();

    // Good frame, ready high: one-cycle write right after the checksum byte.
    frame(8'h10, 8'h3C, 8'h2C);
    check("gf_valid", {31'd0, wr_valid}, 1);
    check("gf_addr", {24'd0, wr_addr}, 32'h10);
    check("gf_data", {24'd0, wr_data}, 32'h3C);
    tick();
    check("gf_valid_drop", {31'd0, wr_valid}, 0);
    check("gf_err", {24'd0, err_count}, 0);

    // Backpressure with an overrun byte during the stall.
    ready = 1'b0;
    frame(8'h10, 8'h3C, 8'h2C);
    vcount = 0;
    for (int i = 0; i < 20; i++) begin
      if (wr_valid) vcount++;
      if (i == 5) send(8'h77); else tick();
    end
    ready = 1'b1;
    if (wr_valid) vcount++;
    check("bp_addr", {24'd0, wr_addr}, 32'h10);
    check("bp_data", {24'd0, wr_data}, 32'h3C);
    tick();
    if (wr_valid) vcount++;
    check("bp_vcount", vcount, 21);
    check("bp_err", {24'd0, err_count}, 1);

    // Bad checksum, then a good frame.
    frame(8'h10, 8'h3C, 8'h00);
    check("bc_valid", {31'd0, wr_valid}, 0);
    check("bc_busy", {31'd0, busy}, 0);
    check("bc_err", {24'd0, err_count}, 2);
    frame(8'h01, 8'h02, 8'h03);
    check("bc2_valid", {31'd0, wr_valid}, 1);
    check("bc2_addr", {24'd0, wr_addr}, 32'h01);
    check("bc2_data", {24'd0, wr_data}, 32'h02);
    tick();

    // Timeout after ADDR byte.
    send(SYNC); send(8'h10);
    repeat (TOC - 1) tick();
    check("to_busy_before", {31'd0, busy}, 1);
    check("to_err_before", {24'd0, err_count}, 2);
    tick();
    check("to_busy", {31'd0, busy}, 0);
    check("to_err", {24'd0, err_count}, 3);

    // Byte landing on the last permitted cycle is accepted.
    send(SYNC); send(8'h10);
    repeat (TOC - 1) tick();
    send(8'h3C); send(8'h2C);
    check("edge_valid", {31'd0, wr_valid}, 1);
    check("edge_err", {24'd0, err_count}, 3);
    tick();

    // Hunt filtering: SYNC value is legal as ADDR.
    send(8'h00); send(8'hFF); send(SYNC); send(SYNC); send(8'h00); send(SYNC);
    check("hunt_valid", {31'd0, wr_valid}, 1);
    check("hunt_addr", {24'd0, wr_addr}, 32'hA5);
    check("hunt_data", {24'd0, wr_data}, 32'h00);
    check("hunt_err", {24'd0, err_count}, 3);
    tick();

    // Saturation.
    for (int i = 0; i < 300; i++) frame(8'h10, 8'h3C, 8'h00);
    check("sat_err", {24'd0, err_count}, 32'hFF);

    // Reset mid-frame.
    send(SYNC); send(8'h10);
    #1 rst_n = 1'b0;
    #1;
    check("mr_valid", {31'd0, wr_valid}, 0);
    check("mr_busy", {31'd0, busy}, 0);
    check("mr_err", {24'd0, err_count}, 0);
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    frame(8'h10, 8'h3C, 8'h2C);
    check("mr2_valid", {31'd0, wr_valid}, 1);
    check("mr2_addr", {24'd0, wr_addr}, 32'h10);
    check("mr2_data", {24'd0, wr_data}, 32'h3C);
    tick();

    // Randomized traffic: good/bad frames, junk, gaps, overruns, occasional timeouts.
    rnd_ready = 1'b1;
    for (int it = 0; it < 250; it++) begin
      int mode;
      logic [7:0] a, d, c;
      repeat ($urandom_range(0, 3)) tick();
      mode = $urandom_range(0, 19);
      a = $urandom_range(0, 255);
      d = $urandom_range(0, 255);
      c = (mode < 14) ? (a ^ d) : (a ^ d ^ 8'h5A);
      if (mode >= 17) send($urandom_range(0, 255));
      else begin
        send(SYNC);
        for (int k = 0; k < 3; k++) begin
          if ($urandom_range(0, 60) == 0) repeat (TOC - 1 + $urandom_range(0, 2)) tick();
          else repeat ($urandom_range(0, 2)) tick();
          send(k == 0 ? a : (k == 1 ? d : c));
        end
      end
    end
    rnd_ready = 1'b0;
    ready = 1'b1;
    repeat (4) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_cmd_decoder.md
Name: uart_cmd_decoder

Overview:
Consumes the byte stream from uart_rx (o_Rx_DV / o_Rx_Byte) and decodes fixed 4-byte command frames: SYNC, ADDR, DATA, CSUM. It issues one register write per valid frame over a valid/ready write port. It enforces an inter-byte timeout, rejects bad checksums and overruns, and keeps a saturating error count. It sits between the UART receiver and the module's control-register file.

Parameters:
SYNC_BYTE, 8'hA5, frame start marker.
TIMEOUT_CLKS, 2560, max clocks between consecutive frame bytes (10 bit times at 256 clks/bit); must be >= 2.
TO_WIDTH, 16, timeout counter width; 2**TO_WIDTH must exceed TIMEOUT_CLKS.

Ports:
i_Clock  in  1  system clock
i_Rst_n  in  1  asynchronous active-low reset
i_Rx_DV  in  1  byte-valid strobe from uart_rx, one cycle per byte
i_Rx_Byte  in  8  received byte, valid when i_Rx_DV=1
o_Wr_Valid  out  1  write request valid
i_Wr_Ready  in  1  register file accepts write (transfer = o_Wr_Valid & i_Wr_Ready)
o_Wr_Addr  out  8  write address
o_Wr_Data  out  8  write data
o_Err_Count  out  8  saturating count of checksum, timeout and overrun errors
o_Busy  out  1  high in any state other than S_HUNT

Behaviour:
- Reset (async assert, sync release), all values 0: o_Wr_Valid, o_Wr_Addr, o_Wr_Data, o_Err_Count, o_Busy; state = S_HUNT; timeout counter = 0.
- States: S_HUNT, S_ADDR, S_DATA, S_CSUM, S_ISSUE. All outputs are registered.
- S_HUNT: on i_Rx_DV with byte == SYNC_BYTE, go to S_ADDR. Other bytes are ignored silently and are not counted as errors.
- S_ADDR: on i_Rx_DV, latch the byte into the address holding reg and go to S_DATA. SYNC_BYTE value is legal here and is not a resync.
- S_DATA: on i_Rx_DV, latch the byte into the data holding reg and go to S_CSUM.
- S_CSUM: on i_Rx_DV, compare byte with ADDR ^ DATA (8-bit XOR).
  - Match: load o_Wr_Addr/o_Wr_Data from the holding regs, set o_Wr_Valid, go to S_ISSUE.
  - Mismatch: o_Err_Count +1, go to S_HUNT, no write issued.
- Latency: CSUM strobe in cycle N gives o_Wr_Valid=1 in cycle N+1.
- S_ISSUE handshake:
  - o_Wr_Valid, o_Wr_Addr and o_Wr_Data are held stable until i_Wr_Ready=1.
  - On transfer, o_Wr_Valid=0 next cycle and state goes to S_HUNT.
  - If i_Wr_Ready is already high in cycle N+1, o_Wr_Valid is high exactly one cycle.
  - o_Wr_Addr/o_Wr_Data keep their last values after transfer.
- Overrun: i_Rx_DV while in S_ISSUE drops the byte, o_Err_Count +1, and the pending write is unaffected. If transfer and overrun occur in the same cycle, the byte is still dropped and counted, and the next state is S_HUNT.
- Timeout:
  - Counter clears on every i_Rx_DV and whenever in S_HUNT or S_ISSUE.
  - Counter increments each cycle in S_ADDR/S_DATA/S_CSUM with no i_Rx_DV.
  - When counter == TIMEOUT_CLKS-1 with no i_Rx_DV that cycle: o_Err_Count +1, go to S_HUNT.
  - If i_Rx_DV coincides with that cycle, the byte is processed normally and there is no timeout.
- o_Err_Count saturates at 8'hFF; further errors leave it at 8'hFF. At most one increment per cycle.
- Reset asserted mid-frame or mid-handshake: immediately returns to the reset state, and any pending write is abandoned (o_Wr_Valid drops asynchronously).
- o_Busy = (state != S_HUNT), registered alongside the state.

Test Plan:
- Good frame with i_Wr_Ready=1: bytes A5,10,3C,2C -> o_Wr_Valid one cycle, 1 clk after the 4th strobe, Addr=8'h10, Data=8'h3C; o_Err_Count=0.
- Backpressure: same frame with i_Wr_Ready=0 for 20 clks, then 1 -> o_Wr_Valid high 21 cycles with Addr/Data stable, then drops. An extra byte strobed during the stall -> o_Err_Count=1, write still 10/3C.
- Bad checksum: A5,10,3C,00 -> no o_Wr_Valid, o_Err_Count=1, o_Busy=0 next cycle. Follow with a good frame A5,01,02,03 -> write 01/02.
- Timeout: A5,10 then idle 2560 clks -> o_Err_Count=1, state S_HUNT. A DV landing on exactly clk 2559 is accepted with no error.
- Hunt filtering and saturation: bytes 00,FF,A5,A5,00,A5 -> only write Addr=A5, Data=00, no errors. Then 300 bad-checksum frames -> o_Err_Count=FF.
- Reset mid-frame: A5,10 then pulse i_Rst_n low 3 clks -> all outputs 0, S_HUNT. A subsequent good frame decodes correctly.
